pipe_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall-vector bit indices,
// FSM encoding, common constants and the stall-priority helper.
package pipe_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_BUS = 6;

  localparam logic        ENABLE  = 1'b1;
  localparam logic        DISABLE = 1'b0;
  localparam logic [31:0] ZERO_32 = 32'h0000_0000;

  typedef enum logic {
    CTRL_RUN        = 1'b0,
    CTRL_WAIT_FETCH = 1'b1
  } ctrl_state_e;

  // Highest requesting stage holds itself and everything upstream; WB never holds.
  function automatic logic [STALL_BUS-1:0] stall_vec(input logic mem, input logic ex,
                                                     input logic id, input logic fetch);
    logic [STALL_BUS-1:0] v;
    v = '0;
    if (mem)        v[STALL_MEM:STALL_PC] = '1;
    else if (ex)    v[STALL_EX:STALL_PC]  = '1;
    else if (id)    v[STALL_ID:STALL_PC]  = '1;
    else if (fetch) v[STALL_IF:STALL_PC]  = '1;
    v[STALL_WB] = DISABLE;
    return v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: combinational stall/flush/redirect from stage requests,
// plus a pending-redirect state for a branch that lands during an in-flight fetch.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          CNT_WIDTH = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_if,
  input  logic                 stallreq_id,
  input  logic                 stallreq_ex,
  input  logic                 stallreq_mem,
  input  logic                 flushreq_ex,
  input  logic [31:0]          target_ex,
  output logic [5:0]           stall,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 new_pc_valid,
  output logic [31:0]          new_pc,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  ctrl_state_e          state, state_nxt;
  logic [31:0]          pend_pc, pend_pc_nxt;
  logic [STALL_BUS-1:0] req_stall;

  assign req_stall = stall_vec(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CTRL_RUN;
      pend_pc <= ZERO_32;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pend_pc_nxt  = pend_pc;
    stall        = req_stall;
    flush_if_id  = DISABLE;
    flush_id_ex  = DISABLE;
    new_pc_valid = DISABLE;
    new_pc       = target_ex;
    if (rst) begin
      stall  = '0;
      new_pc = RESET_PC;
    end else begin
      case (state)
        CTRL_RUN: begin
          // A taken branch squashes the ID instruction, so its load-use stall is moot.
          if (flushreq_ex && !req_stall[STALL_EX]) begin
            stall       = stall_vec(DISABLE, DISABLE, DISABLE, stallreq_if);
            flush_if_id = ENABLE;
            flush_id_ex = ENABLE;
            if (stallreq_if) begin
              state_nxt   = CTRL_WAIT_FETCH;
              pend_pc_nxt = target_ex;
            end else begin
              new_pc_valid = ENABLE;
            end
          end
        end
        CTRL_WAIT_FETCH: begin
          stall       = stall_vec(stallreq_mem, stallreq_ex, stallreq_id, ENABLE);
          flush_if_id = ENABLE;
          new_pc      = pend_pc;
          if (!stallreq_if) begin
            new_pc_valid = ENABLE;
            state_nxt    = CTRL_RUN;
          end
        end
        default: state_nxt = CTRL_RUN;
      endcase
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall[STALL_PC]),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (new_pc_valid),
    .count (flush_count)
  );

endmodule
